// File: rtl/rtc_access_scheduler.sv
// Arbitrates user writes and periodic time-register read bursts onto a single RTC bus FSM.
// Optional watchdog on bus transactions is enabled with `define RTC_SCHED_TIMEOUT_EN.
module rtc_access_scheduler #(
  parameter logic [7:0]  READ_BASE      = 8'h21,
  parameter int unsigned READ_COUNT     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       do_it,
  output logic       w_r,
  output logic [7:0] addr_out,
  output logic [7:0] data_out,
  input  logic       xfer_done,
  input  logic       rd_flag,
  input  logic [7:0] rd_bus,
  output logic [7:0] time_sec,
  output logic [7:0] time_min,
  output logic [7:0] time_hour,
  output logic       time_valid,
  output logic       busy,
  output logic       err
);

  localparam int unsigned IDX_W = 2;

  if (READ_COUNT < 1 || READ_COUNT > 3 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("rtc_access_scheduler: illegal READ_COUNT or TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    IDLE, W_ISSUE, W_WAIT, R_ISSUE, R_WAIT, R_NEXT, DONE
  } state_t;

  state_t           state, state_nx;
  logic             tick_pend, tick_pend_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic             do_it_nx, wr_ack_nx, time_valid_nx, w_r_nx, busy_nx;
  logic [7:0]       addr_nx, data_nx, sec_nx, min_nx, hour_nx;

`ifdef RTC_SCHED_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nx;
  logic             err_q, err_nx;
  logic             tmo_hit_c;

  assign tmo_hit_c = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign err       = err_q;
`else
  assign err = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_nx      = state;
    tick_pend_nx  = tick_pend | tick;
    idx_nx        = idx;
    do_it_nx      = 1'b0;
    wr_ack_nx     = 1'b0;
    time_valid_nx = 1'b0;
    w_r_nx        = w_r;
    addr_nx       = addr_out;
    data_nx       = data_out;
    sec_nx        = time_sec;
    min_nx        = time_min;
    hour_nx       = time_hour;
`ifdef RTC_SCHED_TIMEOUT_EN
    tmo_cnt_nx    = tmo_cnt;
    err_nx        = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (wr_req) begin
          state_nx = W_ISSUE;
        end else if (tick_pend) begin
          // A tick landing in this very cycle stays pending for the next burst.
          tick_pend_nx = tick;
          idx_nx       = '0;
          state_nx     = R_ISSUE;
        end
      end

      W_ISSUE: begin
        addr_nx  = wr_addr;
        data_nx  = wr_data;
        w_r_nx   = 1'b1;
        do_it_nx = 1'b1;
        state_nx = W_WAIT;
`ifdef RTC_SCHED_TIMEOUT_EN
        tmo_cnt_nx = '0;
`endif
      end

      W_WAIT: begin
`ifdef RTC_SCHED_TIMEOUT_EN
        tmo_cnt_nx = TMO_W'(tmo_cnt + 1'b1);
`endif
        if (xfer_done) begin
          wr_ack_nx = 1'b1;
          state_nx  = IDLE;
        end
`ifdef RTC_SCHED_TIMEOUT_EN
        else if (tmo_hit_c) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
`endif
      end

      R_ISSUE: begin
        addr_nx  = READ_BASE + 8'(idx);
        w_r_nx   = 1'b0;
        do_it_nx = 1'b1;
        state_nx = R_WAIT;
`ifdef RTC_SCHED_TIMEOUT_EN
        tmo_cnt_nx = '0;
`endif
      end

      R_WAIT: begin
`ifdef RTC_SCHED_TIMEOUT_EN
        tmo_cnt_nx = TMO_W'(tmo_cnt + 1'b1);
`endif
        if (rd_flag) begin
          case (idx)
            2'd0:    sec_nx  = rd_bus;
            2'd1:    min_nx  = rd_bus;
            2'd2:    hour_nx = rd_bus;
            default: ;
          endcase
        end
        if (xfer_done) begin
          state_nx = R_NEXT;
        end
`ifdef RTC_SCHED_TIMEOUT_EN
        else if (tmo_hit_c) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
`endif
      end

      R_NEXT: begin
        if (idx == IDX_W'(READ_COUNT - 1)) begin
          state_nx = DONE;
        end else begin
          idx_nx   = IDX_W'(idx + 1'b1);
          state_nx = R_ISSUE;
        end
      end

      DONE: begin
        time_valid_nx = 1'b1;
        state_nx      = IDLE;
      end

      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tick_pend  <= 1'b0;
      idx        <= '0;
      do_it      <= 1'b0;
      wr_ack     <= 1'b0;
      time_valid <= 1'b0;
      w_r        <= 1'b0;
      addr_out   <= 8'h00;
      data_out   <= 8'h00;
      time_sec   <= 8'h00;
      time_min   <= 8'h00;
      time_hour  <= 8'h00;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      tick_pend  <= tick_pend_nx;
      idx        <= idx_nx;
      do_it      <= do_it_nx;
      wr_ack     <= wr_ack_nx;
      time_valid <= time_valid_nx;
      w_r        <= w_r_nx;
      addr_out   <= addr_nx;
      data_out   <= data_nx;
      time_sec   <= sec_nx;
      time_min   <= min_nx;
      time_hour  <= hour_nx;
      busy       <= busy_nx;
    end
  end

`ifdef RTC_SCHED_TIMEOUT_EN
  // Transaction watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= tmo_cnt_nx;
      err_q   <= err_nx;
    end
  end
`endif

endmodule

// File: doc/rtc_access_scheduler.md
RTC_ACCESS_SCHEDULER -- requirements
Module: rtc_access_scheduler

Interface
REQ-001 Parameter READ_BASE, default 8'h21: address of the first time register read in a burst.
REQ-002 Parameter READ_COUNT, default 3, legal range 1..3: number of consecutive registers read per burst.
REQ-003 Parameter TIMEOUT_CYCLES, default 64: watchdog limit per transaction; used only when RTC_SCHED_TIMEOUT_EN is defined.
REQ-004 Ports, in order:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high.
- tick, input, 1: periodic read-burst request pulse.
- wr_req, input, 1: user write request; level, held until wr_ack.
- wr_addr, input, 8: write address.
- wr_data, input, 8: write data.
- wr_ack, output, 1: one-cycle pulse when the write completes.
- do_it, output, 1: start pulse to the RTC bus FSM.
- w_r, output, 1: 1 = write, 0 = read, to the bus FSM.
- addr_out, output, 8: address for the bus FSM.
- data_out, output, 8: write data for the bus FSM.
- xfer_done, input, 1: one-cycle pulse when the bus FSM returns to idle.
- rd_flag, input, 1: bus FSM read-data-valid flag.
- rd_bus, input, 8: data sampled from the RTC bus.
- time_sec, output, 8; time_min, output, 8; time_hour, output, 8: captured registers at offsets 0, 1 and 2.
- time_valid, output, 1: one-cycle pulse when a burst finishes.
- busy, output, 1: high whenever the FSM is not in IDLE.
- err, output, 1: one-cycle pulse on timeout.

Function
REQ-005 The FSM SHALL have the states IDLE, W_ISSUE, W_WAIT, R_ISSUE, R_WAIT, R_NEXT and DONE.
REQ-006 In IDLE, if wr_req=1 the FSM SHALL go to W_ISSUE. Otherwise, if tick_pend=1 it SHALL clear tick_pend, reset idx to 0 and go to R_ISSUE. Writes have priority.
REQ-007 A tick received in any cycle SHALL set tick_pend. Multiple ticks SHALL collapse into one pending burst.
REQ-008 A tick arriving in the same cycle IDLE consumes tick_pend SHALL be retained in tick_pend.
REQ-009 W_ISSUE SHALL:
- register wr_addr into addr_out and wr_data into data_out;
- drive w_r=1;
- pulse do_it for exactly one cycle;
- go to W_WAIT.
REQ-010 In W_WAIT, xfer_done=1 SHALL pulse wr_ack for one cycle and return to IDLE.
REQ-011 R_ISSUE SHALL drive addr_out=READ_BASE+idx (8-bit wrap) and w_r=0, pulse do_it for one cycle, and go to R_WAIT.
REQ-012 In R_WAIT, every cycle with rd_flag=1 SHALL load rd_bus into the time register selected by idx. The last such sample wins.
REQ-013 In R_WAIT, xfer_done=1 SHALL go to R_NEXT.
REQ-014 In R_NEXT, if idx=READ_COUNT-1 the FSM SHALL go to DONE; otherwise it SHALL increment idx and go to R_ISSUE.
REQ-015 A burst SHALL NOT be interrupted: wr_req asserted mid-burst waits until IDLE.
REQ-016 DONE SHALL pulse time_valid for one cycle and return to IDLE.
REQ-017 addr_out, data_out and w_r SHALL hold stable from the ISSUE state until the matching WAIT state exits.
REQ-018 Latency: do_it SHALL assert 2 cycles after wr_req rises in IDLE (IDLE→W_ISSUE, registered output).
REQ-019 Time registers not read in a burst (READ_COUNT<3) SHALL retain their previous value.
REQ-020 xfer_done or rd_flag received outside a WAIT state SHALL be ignored.

Reset
REQ-021 reset SHALL asynchronously force:
- the state to IDLE;
- tick_pend=0 and idx=0;
- do_it=0, wr_ack=0, time_valid=0 and err=0;
- w_r=0;
- addr_out, data_out and all time registers to 8'h00.
REQ-022 Reset mid-transaction SHALL abandon the transaction without issuing wr_ack or time_valid. A pending tick is lost.

Configuration
REQ-023 With RTC_SCHED_TIMEOUT_EN defined, a counter SHALL clear on each do_it and increment in each WAIT state.
REQ-024 With RTC_SCHED_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without xfer_done SHALL pulse err for one cycle and return to IDLE:
- a write stays unacknowledged and is retried while wr_req remains high;
- a burst is aborted with no time_valid.
REQ-025 Without RTC_SCHED_TIMEOUT_EN, WAIT states SHALL wait indefinitely, err SHALL be tied 0, and no counter logic SHALL exist.

Verification
REQ-026 wr_req=1, wr_addr=8'h02, wr_data=8'h45, xfer_done 20 cycles after do_it -> one do_it pulse with w_r=1, addr_out=02, data_out=45; one wr_ack pulse; return to IDLE.
REQ-027 tick pulse; model returns rd_bus=12, 34, 56 for addresses 21, 22, 23 -> three do_it pulses with w_r=0; time_sec=12, time_min=34, time_hour=56; one time_valid pulse.
REQ-028 tick and wr_req in the same IDLE cycle -> write completes first, then the read burst runs.
REQ-029 wr_req during the second read of a burst -> burst finishes with time_valid before the write's do_it.
REQ-030 Three ticks during one burst -> exactly one further burst.
REQ-031 RTC_SCHED_TIMEOUT_EN defined, xfer_done never asserted -> err pulses 64 cycles after do_it, state IDLE; reset asserted mid-R_WAIT -> all outputs at reset values immediately.
